// File: rtl/fgen_burst_wf_pkg.sv
// rtl/fgen_burst_wf_pkg.sv - shared widths, state encoding and frequency-to-F helpers for fgen_burst_wf
package fgen_burst_wf_pkg;

  localparam int FGEN_M_ACC = 32;
  localparam int FGEN_M_F   = 32;
  localparam int FGEN_M_N   = 16;

  localparam longint unsigned FGEN_FCLK_HZ = 64'd100_000_000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fgen_state_e;

  // F = Fout * 2^m_acc / Fclk, truncated; valid for fout_hz < 2^32 and m_acc <= 32
  function automatic logic [63:0] fgen_freq_to_f(input logic [63:0] fout_hz, input int m_acc);
    return (fout_hz << m_acc) / FGEN_FCLK_HZ;
  endfunction

endpackage

`ifndef FGEN_CONST_FCLK_HZ
`define FGEN_CONST_FCLK_HZ 100_000_000
`endif

`ifndef FGEN_FREQ_TO_F
`define FGEN_FREQ_TO_F(fout_hz, m_acc) fgen_burst_wf_pkg::fgen_freq_to_f(64'(fout_hz), m_acc)
`endif

// File: rtl/fgen_phase_acc.sv
// rtl/fgen_phase_acc.sv - phase accumulator with carry out, clock enable, sync clear and registered MSB
module fgen_phase_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] inc_i,
  output logic         carry_o,
  output logic         msb_o
);

  logic [W-1:0] acc_q, acc_d;
  logic [W:0]   sum;
  logic         msb_q;

  assign sum     = {1'b0, acc_q} + {1'b0, inc_i};
  // Carry is not gated by clr_i: the owner decides precedence and uses carry to build clr_i.
  assign carry_o = en_i & sum[W];
  assign msb_o   = msb_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      msb_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      msb_q <= acc_d[W-1];
    end
  end

endmodule

// File: rtl/fgen_burst_wf.sv
// rtl/fgen_burst_wf.sv - burst/continuous square-wave generator; optional FGEN_SYNC_LOAD_EN adds period-aligned F reload
module fgen_burst_wf
  import fgen_burst_wf_pkg::*;
#(
  parameter int M_ACC = FGEN_M_ACC,
  parameter int M_F   = FGEN_M_F,
  parameter int M_N   = FGEN_M_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce_i,
  input  logic           st_i,
  input  logic           stp_i,
  input  logic [M_F-1:0] f_i,
  input  logic [M_N-1:0] n_i,
`ifdef FGEN_SYNC_LOAD_EN
  input  logic           ld_i,
  output logic           ld_ack_o,
`endif
  output logic           ux_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [M_N-1:0] cnt_o
);

  fgen_state_e    state_q;
  logic [M_F-1:0] f_r_q;
  logic [M_N-1:0] n_r_q;
  logic [M_N-1:0] cnt_q;
  logic [M_N-1:0] cnt_inc;
  logic           busy_q, done_q;
  logic           start, carry, finish, acc_clr, acc_en;

  // A start with F==0 would never produce a carry, so it is ignored in either state.
  assign start   = st_i && (f_i != '0);
  assign acc_en  = (state_q == S_RUN) && ce_i;
  assign cnt_inc = cnt_q + M_N'(1);
  assign finish  = (state_q == S_RUN) && carry && (n_r_q != '0) && (cnt_inc == n_r_q)
                   && !stp_i && !start;
  assign acc_clr = stp_i || start || finish;

  fgen_phase_acc #(.W(M_ACC)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (acc_clr),
    .en_i    (acc_en),
    .inc_i   (M_ACC'(f_r_q)),
    .carry_o (carry),
    .msb_o   (ux_o)
  );

`ifdef FGEN_SYNC_LOAD_EN
  logic [M_F-1:0] f_nxt_q;
  logic           pend_q, ld_ack_q;
  assign ld_ack_o = ld_ack_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f_r_q   <= '0;
      n_r_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FGEN_SYNC_LOAD_EN
      f_nxt_q  <= '0;
      pend_q   <= 1'b0;
      ld_ack_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (stp_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (start) begin
        f_r_q   <= f_i;
        n_r_q   <= n_i;
        cnt_q   <= '0;
        state_q <= S_RUN;
        busy_q  <= 1'b1;
      end else if (finish) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        cnt_q   <= n_r_q;
      end else if (carry && !((n_r_q == '0) && (&cnt_q))) begin
        cnt_q <= cnt_inc;
      end
`ifdef FGEN_SYNC_LOAD_EN
      ld_ack_q <= 1'b0;
      if (stp_i || start) begin
        pend_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
        if (ld_i) begin
          f_r_q    <= f_i;
          ld_ack_q <= 1'b1;
        end
      end else begin
        // Swap at the carry edge so the new increment starts a fresh period without a phase reset.
        if (carry && pend_q) begin
          f_r_q    <= f_nxt_q;
          pend_q   <= 1'b0;
          ld_ack_q <= 1'b1;
        end
        if (ld_i) begin
          f_nxt_q <= f_i;
          pend_q  <= 1'b1;
        end
      end
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_fgen_burst_wf.sv
// tb/tb_fgen_burst_wf.sv - directed self-checking bench for fgen_burst_wf (M_ACC=8, M_F=8, M_N=4)
module tb_fgen_burst_wf;
  localparam int M_ACC = 8;
  localparam int M_F   = 8;
  localparam int M_N   = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ce = 1'b1;
  logic           st = 1'b0;
  logic           stp = 1'b0;
  logic [M_F-1:0] f = '0;
  logic [M_N-1:0] n = '0;
  logic           ux, busy, done;
  logic [M_N-1:0] cnt;
`ifdef FGEN_SYNC_LOAD_EN
  logic           ld = 1'b0;
  logic           ld_ack;
`endif

  int nvec = 0;
  int nerr = 0;

  int         edges, falls, last, pmin, pmax, busy_low, done_seen, ack_seen;
  logic       prev;
  logic [11:0] uxv;

  always #5 clk = ~clk;

  fgen_burst_wf #(.M_ACC(M_ACC), .M_F(M_F), .M_N(M_N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce_i   (ce),
    .st_i   (st),
    .stp_i  (stp),
    .f_i    (f),
    .n_i    (n),
`ifdef FGEN_SYNC_LOAD_EN
    .ld_i     (ld),
    .ld_ack_o (ld_ack),
`endif
    .ux_o   (ux),
    .busy_o (busy),
    .done_o (done),
    .cnt_o  (cnt)
  );

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic [M_F-1:0] fv, input logic [M_N-1:0] nv);
    f  = fv;
    n  = nv;
    st = 1'b1;
    clk1();
    st = 1'b0;
  endtask

  task automatic abort();
    stp = 1'b1;
    clk1();
    stp = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int e_out);
    e_out = -1;
    for (int i = 1; i <= lim; i++) begin
      clk1();
      if (done === 1'b1) begin
        e_out = i;
        break;
      end
    end
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_ux", 32'(ux), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    #11 rst_n = 1'b1;
    clk1();

    // burst F=64 N=3: 0,0,1,1 x3, done on edge 12
    start_burst(8'd64, 4'd3);
    uxv = '0;
    uxv[0] = ux;
    busy_low = (busy !== 1'b1) ? 1 : 0;
    done_seen = (done !== 1'b0) ? 1 : 0;
    for (int k = 1; k < 12; k++) begin
      clk1();
      uxv[k] = ux;
      if (busy !== 1'b1) busy_low++;
      if (done !== 1'b0) done_seen++;
      if (k == 5) chk("burst_cnt_k5", 32'(cnt), 32'd1);
      if (k == 9) chk("burst_cnt_k9", 32'(cnt), 32'd2);
    end
    chk("burst_ux_pattern", 32'(uxv), 32'hCCC);
    chk("burst_busy_12", 32'(busy_low), 32'd0);
    chk("burst_no_early_done", 32'(done_seen), 32'd0);
    clk1();
    chk("burst_done_e12", 32'(done), 32'd1);
    chk("burst_busy_off", 32'(busy), 32'd0);
    chk("burst_cnt_end", 32'(cnt), 32'd3);
    chk("burst_ux_end", 32'(ux), 32'd0);
    clk1();
    chk("burst_done_pulse", 32'(done), 32'd0);
    chk("burst_ux_idle", 32'(ux), 32'd0);

    // fractional F=96 continuous: 96 carries in 256 clks, periods 2 or 3
    start_burst(8'd96, 4'd0);
    prev = ux;
    falls = 0; last = 0; pmin = 99; pmax = 0; busy_low = 0; done_seen = 0;
    for (int e = 1; e <= 256; e++) begin
      clk1();
      if (prev && !ux) begin
        falls++;
        if (e - last < pmin) pmin = e - last;
        if (e - last > pmax) pmax = e - last;
        last = e;
      end
      prev = ux;
      if (busy !== 1'b1) busy_low++;
      if (done !== 1'b0) done_seen++;
    end
    chk("frac_carries", 32'(falls), 32'd96);
    chk("frac_pmin", 32'(pmin), 32'd2);
    chk("frac_pmax", 32'(pmax), 32'd3);
    chk("frac_busy", 32'(busy_low), 32'd0);
    chk("frac_no_done", 32'(done_seen), 32'd0);
    chk("frac_cnt_sat", 32'(cnt), 32'd15);
    abort();
    chk("frac_stp_busy", 32'(busy), 32'd0);
    chk("frac_stp_ux", 32'(ux), 32'd0);

    // ce gating: F=64 N=2, 5-clk gap after edge 2, done at edge 13
    start_burst(8'd64, 4'd2);
    clk1();
    clk1();
    chk("ce_ux_before", 32'(ux), 32'd1);
    ce = 1'b0;
    uxv = '0;
    for (int k = 0; k < 5; k++) begin
      clk1();
      uxv[k] = ux;
    end
    chk("ce_ux_frozen", 32'(uxv), 32'h1F);
    chk("ce_busy_gap", 32'(busy), 32'd1);
    ce = 1'b1;
    wait_done(30, edges);
    chk("ce_done_edge", 32'(edges + 7), 32'd13);
    chk("ce_cnt", 32'(cnt), 32'd2);

    // abort at clk 5 of an N=4 burst
    clk1();
    start_burst(8'd64, 4'd4);
    for (int k = 1; k < 5; k++) clk1();
    abort();
    chk("stp_busy", 32'(busy), 32'd0);
    chk("stp_ux", 32'(ux), 32'd0);
    chk("stp_done", 32'(done), 32'd0);
    wait_done(20, edges);
    chk("stp_no_done", 32'(edges), 32'hFFFF_FFFF);

    // restart at clk 6, done 16 clks after second st
    start_burst(8'd64, 4'd4);
    for (int k = 1; k < 6; k++) clk1();
    chk("rs_cnt_before", 32'(cnt), 32'd1);
    start_burst(8'd64, 4'd4);
    chk("rs_cnt_zero", 32'(cnt), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_done", 32'(done), 32'd0);
    wait_done(40, edges);
    chk("rs_done_edge", 32'(edges), 32'd16);
    chk("rs_cnt_end", 32'(cnt), 32'd4);

    // F=0 start is ignored
    start_burst(8'd0, 4'd2);
    chk("f0_busy", 32'(busy), 32'd0);
    clk1();
    chk("f0_busy2", 32'(busy), 32'd0);
    chk("f0_done", 32'(done), 32'd0);

    // async reset mid-burst
    start_burst(8'd64, 4'd3);
    for (int k = 1; k <= 6; k++) clk1();
    chk("ar_ux_pre", 32'(ux), 32'd1);
    chk("ar_cnt_pre", 32'(cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ux", 32'(ux), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_cnt", 32'(cnt), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;
    clk1();

`ifdef FGEN_SYNC_LOAD_EN
    // sync load: F=32 running, ld F=128 before edge 3, switch on carry at edge 8
    start_burst(8'd32, 4'd0);
    uxv = '0;
    ack_seen = 0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 3) begin
        f  = 8'd128;
        ld = 1'b1;
      end
      clk1();
      ld = 1'b0;
      uxv[e-1] = ux;
      if (ld_ack === 1'b1) begin
        if (ack_seen == 0) ack_seen = e;
        else ack_seen = 99;
      end
    end
    chk("ld_ux_pattern", 32'(uxv), 32'h578);
    chk("ld_ack_edge", 32'(ack_seen), 32'd8);
    abort();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fgen_burst_wf.md
Name: fgen_burst_wf

Overview:
Programmable test-frequency generator. It is the source-side counterpart of the reciprocal frequency meter.
- Produces a square wave Ux whose frequency is set by a phase-increment word F, using a phase accumulator.
- Output is either a burst of exactly N periods or a continuous wave.
- Drives the meter's Ux input in lab self-test, so that measured F can be checked against a known setting.

Parameters:
- M_ACC, 32: accumulator width; Fout = F*Fclk/2^M_ACC.
- M_F, 32: width of the F word (M_F <= M_ACC, zero-extended).
- M_N, 16: width of the burst period count N.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- ce, in, 1: clock enable for the accumulator; when low, phase and count hold.
- st, in, 1: start pulse; latches F and N and begins generation.
- stp, in, 1: abort; returns to IDLE.
- F, in, M_F: phase increment word.
- N, in, M_N: number of periods; 0 means continuous.
- Ux, out, 1: generated square wave (accumulator MSB, registered).
- busy, out, 1: high in RUN.
- done, out, 1: one-clk pulse at normal burst end.
- cnt, out, M_N: number of periods completed in the current burst.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc=0, cnt=0, F_r=0, N_r=0, Ux=0, busy=0, done=0.
- States: IDLE, RUN. done is a registered pulse, not a state.
- IDLE:
  - st=1 and F!=0 at a clk edge: F_r<=F, N_r<=N, acc<=0, cnt<=0, state<=RUN. busy is 1 from the next cycle.
  - st with F==0: ignored; no busy, no done.
- RUN, each edge with ce=1: {carry,acc} <= acc + F_r.
  - Ux = acc[M_ACC-1] (register output, no glitches).
  - A carry marks the end of one period: cnt<=cnt+1, saturating at all-ones in continuous mode.
  - N_r!=0 and the carry makes cnt+1==N_r: state<=IDLE, acc<=0, done<=1 for one cycle, cnt holds N_r.
  - The burst therefore holds exactly N_r full periods, each starting low.
- RUN with ce=0: acc, cnt and Ux hold.
- st during RUN: restart. Relatch F and N, acc<=0, cnt<=0, stay RUN, no done.
- stp (any state): state<=IDLE, acc<=0, Ux<=0, no done. stp has priority over st in the same cycle.
- done and stp in the same cycle: stp wins, done=0.
- Period length: exact when 2^M_ACC/F_r is an integer; otherwise jitter of one clk with exact average frequency.
- Width rule: F is zero-extended to M_ACC bits; the carry is bit M_ACC of the sum.

Optional Feature:
FGEN_SYNC_LOAD_EN
- Defined:
  - Adds input ld (1 bit) and output ld_ack (1-clk pulse).
  - ld in RUN stores F into F_nxt and sets pending.
  - At the next carry, F_r<=F_nxt and pending clears; ld_ack pulses on that edge.
  - Frequency therefore changes only at a period boundary, with no phase reset and no truncated period.
  - A second ld before the boundary overwrites F_nxt.
  - ld in IDLE loads F_r directly, and ld_ack pulses next cycle.
- Undefined: no ld/ld_ack ports; F changes only via st.

Decomposition:
- Shared package/include, alongside the CONST_XY defines:
  - defaults for M_ACC, M_F, M_N;
  - state encoding constants S_IDLE and S_RUN;
  - a macro converting a target frequency to F for the board Fclk.
- One natural sub-module, fgen_phase_acc: the accumulator plus carry and MSB register, with ce and sync clear. The FSM, counter and handshakes stay in the top level.

Test Plan:
- Bench setup for all cases: M_ACC=8, M_F=8, M_N=4, ce=1.
- Burst: F=64, N=3, st pulse -> Ux per clk 0,0,1,1 repeated 3 times; busy high 12 clks; done pulse on the 12th edge after st; cnt=3; Ux=0 afterwards.
- Fractional: F=96, N=0, run 256 clks -> exactly 96 carries, periods of 2 or 3 clks only (average 8/3); busy stays high; done never asserted.
- ce gating: F=64, N=2, ce low for 5 clks mid-burst -> Ux frozen during the gap; done 8+5 clks after st; cnt=2.
- Abort/restart:
  - stp at clk 5 of an N=4 burst -> IDLE, Ux=0, no done.
  - st at clk 6 of a new burst -> cnt restarts at 0; done 4N clks after the second st.
- Edge cases:
  - F=0 with st -> busy stays 0.
  - Async rst_n low mid-burst -> all outputs 0 immediately, without waiting for a clk edge.
- FGEN_SYNC_LOAD_EN: F=32, N=0 running; ld with F=128 at clk 3 -> first 8-clk period completes, then 2-clk periods; ld_ack on the switching edge.
